// File: rtl/craft_sbox_layer_seq.sv
// rtl/craft_sbox_layer_seq.sv - sequential CRAFT S-box layer, LANES nibbles per clock
//
// Purpose: substitutes every nibble of a DATA_WIDTH-bit state through the
// involutory CRAFT S-box. LANES nibbles are processed per cycle, so one block
// takes NCHUNK = DATA_WIDTH/(4*LANES) cycles. Input and output use
// valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort, returns to IDLE (work register kept)
//   in_valid   input state valid
//   in_ready   block can accept a state
//   in_data    input state, DATA_WIDTH bits
//   out_valid  result valid (DONE state)
//   out_ready  downstream accepts result
//   out_data   substituted state, registered
module craft_sbox_layer_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int SW     = 4 * LANES;
  localparam int NCHUNK = DATA_WIDTH / SW;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (LANES < 1 || LANES > DATA_WIDTH / 4 || (DATA_WIDTH % SW) != 0) begin : g_param_check
      $error("craft_sbox_layer_seq: DATA_WIDTH must be a multiple of 4*LANES, LANES in 1..DATA_WIDTH/4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] work_q;
  logic [SW-1:0]         sub_lo;
  logic [DATA_WIDTH-1:0] work_step;
  logic                  last_chunk;
  logic                  accept;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hc;
      4'h1: y = 4'ha;
      4'h2: y = 4'hd;
      4'h3: y = 4'h3;
      4'h4: y = 4'he;
      4'h5: y = 4'hb;
      4'h6: y = 4'hf;
      4'h7: y = 4'h7;
      4'h8: y = 4'h8;
      4'h9: y = 4'h9;
      4'ha: y = 4'h1;
      4'hb: y = 4'h5;
      4'hc: y = 4'h0;
      4'hd: y = 4'h2;
      4'he: y = 4'h4;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  // Substitute the low LANES nibbles of the work register.
  always_comb begin
    sub_lo = '0;
    for (int i = 0; i < LANES; i++) begin
      sub_lo[4*i +: 4] = sbox(work_q[4*i +: 4]);
    end
  end

  // Substituted chunk re-enters at the top so that after NCHUNK steps the
  // nibble order is back where it started.
  generate
    if (NCHUNK == 1) begin : g_single
      assign work_step = sub_lo;
    end else begin : g_rotate
      assign work_step = {sub_lo, work_q[DATA_WIDTH-1:SW]};
    end
  endgenerate

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));
  assign accept     = in_valid && in_ready && !clr;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (last_chunk) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
    end
  end

  // FSM: outputs. in_ready depends on out_ready only while DONE, which is
  // what lets a consume and a new accept share one edge.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  // Datapath: work register and chunk counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      work_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      work_q <= in_data;
      cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      work_q <= work_step;
      cnt_q  <= last_chunk ? '0 : cnt_q + CW'(1);
    end
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_craft_sbox_layer_seq.sv
// tb/tb_craft_sbox_layer_seq.sv - self-checking bench for craft_sbox_layer_seq
module tb_craft_sbox_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  logic        sw_valid;
  logic [63:0] sw_in;
  logic        sw_ready  [4];
  logic        sw_ovalid [4];
  logic [63:0] sw_odata  [3];
  logic [15:0] s16_odata;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  craft_sbox_layer_seq #(.DATA_WIDTH(64), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 16;
    craft_sbox_layer_seq #(.DATA_WIDTH(64), .LANES(L)) u_sw (
      .clk(clk), .rst_n(rst_n), .clr(1'b0),
      .in_valid(sw_valid), .in_ready(sw_ready[g]), .in_data(sw_in),
      .out_valid(sw_ovalid[g]), .out_ready(1'b1), .out_data(sw_odata[g])
    );
  end

  craft_sbox_layer_seq #(.DATA_WIDTH(16), .LANES(4)) u_s16 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .in_valid(sw_valid), .in_ready(sw_ready[3]), .in_data(sw_in[15:0]),
    .out_valid(sw_ovalid[3]), .out_ready(1'b1), .out_data(s16_odata)
  );

  // Nibble i of this word is S(i).
  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h642051987fbe3dac;
    return t[4*x +: 4];
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = ref_sbox(v[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    if (!out_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_out(input string tag);
    if (exp_q.size() == 0) chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    else chk(tag, out_data, exp_q.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [63:0] expv;
    logic [63:0] vec;
    logic        seen [4];
    int          lat  [4];
    lat = '{16, 8, 1, 1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    sw_valid = 1'b0; sw_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // 1: single block, latency 4
    in_data = 64'h0123456789abcdef; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(ref_word(in_data));
    chk("t1_ready_idle", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy_ready", in_ready, 1'b0);
      chk("t1_busy_valid", out_valid, 1'b0);
      tick();
    end
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_const", out_data, 64'hcad3ebf789150246);
    check_out("t1_data");
    tick();
    chk("t1_consumed", out_valid, 1'b0);

    // 2: back-to-back with out_ready tied high
    in_data = 64'h0; in_valid = 1'b1;
    exp_q.push_back(ref_word(in_data));
    tick();
    in_data = 64'hffffffffffffffff;
    exp_q.push_back(ref_word(in_data));
    wait_valid(n);
    chk("t2_lat_a", n, 4);
    chk("t2_const_a", out_data, 64'hcccccccccccccccc);
    check_out("t2_data_a");
    chk("t2_ready_done", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t2_b2b_valid", out_valid, 1'b0);
    chk("t2_b2b_ready", in_ready, 1'b0);
    wait_valid(n);
    chk("t2_lat_b", n, 4);
    chk("t2_const_b", out_data, 64'h6666666666666666);
    check_out("t2_data_b");
    tick();

    // 3: backpressure
    out_ready = 1'b0;
    in_data = 64'hfedcba9876543210; in_valid = 1'b1;
    expv = ref_word(in_data);
    exp_q.push_back(expv);
    tick();
    in_valid = 1'b0; in_data = 64'hdeadbeefdeadbeef;
    wait_valid(n);
    chk("t3_lat", n, 4);
    check_out("t3_data");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_data", out_data, expv);
      chk("t3_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_ready_comb", in_ready, 1'b1);
    tick();
    chk("t3_consumed", out_valid, 1'b0);

    // 4: involution
    in_data = 64'hcad3ebf789150246; in_valid = 1'b1;
    exp_q.push_back(ref_word(in_data));
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t4_const", out_data, 64'h0123456789abcdef);
    check_out("t4_data");
    tick();

    // 6a: clr mid-BUSY at counter 2
    in_data = 64'h1122334455667788; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr_valid", out_valid, 1'b0);
    chk("t6_clr_ready", in_ready, 1'b1);
    in_valid = 1'b1; clr = 1'b1; in_data = 64'h1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("t6_clr_no_accept", in_ready, 1'b1);
    in_data = 64'h89abcdef01234567; in_valid = 1'b1;
    exp_q.push_back(ref_word(in_data));
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t6_clr_lat", n, 4);
    check_out("t6_clr_data");
    tick();

    // 6b: asynchronous reset mid-BUSY
    in_data = 64'h5555aaaa5555aaaa; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_data", out_data, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_rst_idle_ready", in_ready, 1'b1);
    chk("t6_rst_idle_valid", out_valid, 1'b0);
    in_data = 64'h0f1e2d3c4b5a6978; in_valid = 1'b1;
    exp_q.push_back(ref_word(in_data));
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t6_rst_lat", n, 4);
    check_out("t6_rst_data_after");
    tick();
    chk("queue_drained", exp_q.size(), 0);

    // 5: parameter sweep against the reference model
    for (int v = 0; v < 1000; v++) begin
      vec = {$urandom, $urandom};
      expv = ref_word(vec);
      sw_in = vec; sw_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        chk("sw_ready", sw_ready[k], 1'b1);
        seen[k] = 1'b0;
      end
      tick();
      sw_valid = 1'b0;
      n = 0;
      while (!(seen[0] && seen[1] && seen[2] && seen[3]) && n < 40) begin
        tick();
        n++;
        for (int k = 0; k < 4; k++) begin
          if (sw_ovalid[k] && !seen[k]) begin
            seen[k] = 1'b1;
            chk("sw_latency", n, lat[k]);
            if (k < 3) chk("sw_data64", sw_odata[k], expv);
            else       chk("sw_data16", {48'd0, s16_odata}, {48'd0, expv[15:0]});
          end
        end
      end
      for (int k = 0; k < 4; k++) chk("sw_seen", seen[k], 1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
